hls_handshake_perf_monitor: RTL and testbench

- Synthesizable, parametrised successor to the testbench-only dataflow status monitor.
- Observes NUM_CH HLS block-level handshakes (ap_start/ap_ready/ap_done/ap_continue) and keeps per-channel counters in RTL: transactions, busy cycles, continue-stall cycles and ready count.
- Counters are read through a registered select port, so the same statistics are available on FPGA or in co-simulation without CSV dumping.
- Sits beside the top-level IP (e.g. fetching_ip and its sub-blocks) and taps their handshake signals.

---
 rtl/hls_handshake_perf_monitor.sv | 233 +++++++++++++++++++++++
 tb/tb_hls_handshake_perf_monitor.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_handshake_perf_monitor.sv
// Purpose : per-channel statistics for HLS ap_start/ap_ready/ap_done/ap_continue handshakes.
// Latency : counters update on the edge after the observed cycle; rd_req in cycle N -> rd_data/rd_valid in N+1.
// Backpressure: passive tap, never stalls the observed blocks; the read port accepts a request every cycle.
//
// Ports:
//   clock, reset (async, active-low)   -- single clock domain
//   enable, clear, finish              -- counting gate, synchronous clear, end-of-run freeze
//   ch_start/ch_ready/ch_done/ch_continue [NUM_CH] -- tapped handshakes
//   rd_sel, rd_field, rd_req -> rd_data, rd_valid, rd_err -- registered counter read port
//   all_idle, any_overflow, finish_seen -- status
// Optional: define HLS_PERF_MAXLAT_EN to build per-channel latency tracking (field 4 = max_latency).
module hls_handshake_perf_monitor #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int SEL_W  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              clear,
   input  logic              finish,
   input  logic [NUM_CH-1:0] ch_start,
   input  logic [NUM_CH-1:0] ch_ready,
   input  logic [NUM_CH-1:0] ch_done,
   input  logic [NUM_CH-1:0] ch_continue,
   input  logic [SEL_W-1:0]  rd_sel,
   input  logic [2:0]        rd_field,
   input  logic              rd_req,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_valid,
   output logic              rd_err,
   output logic              all_idle,
   output logic              any_overflow,
   output logic              finish_seen
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY      = 2'd1,
      WAIT_CONT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   state_t            st_q     [NUM_CH];
   state_t            st_d     [NUM_CH];
   logic [CNT_W-1:0]  txn_q    [NUM_CH];
   logic [CNT_W-1:0]  busy_q   [NUM_CH];
   logic [CNT_W-1:0]  stall_q  [NUM_CH];
   logic [CNT_W-1:0]  ready_q  [NUM_CH];
   logic [NUM_CH-1:0] ovf_q;
   logic [NUM_CH-1:0] txn_inc, busy_inc, stall_inc, rdy_inc, accept, ovf_hit;
   logic              count_en;
   logic              idle_now;
`ifdef HLS_PERF_MAXLAT_EN
   logic [CNT_W-1:0]  lat_q    [NUM_CH];
   logic [CNT_W-1:0]  lat_d    [NUM_CH];
   logic [CNT_W-1:0]  lat_cur  [NUM_CH];
   logic [CNT_W-1:0]  max_q    [NUM_CH];
   logic [CNT_W-1:0]  max_d    [NUM_CH];
`endif

   assign count_en     = enable & ~finish_seen;
   assign any_overflow = |ovf_q;

   // Next-state and increment decode for every channel.
   always_comb begin
      idle_now = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         st_d[i]      = st_q[i];
         txn_inc[i]   = 1'b0;
         busy_inc[i]  = 1'b0;
         stall_inc[i] = 1'b0;
         accept[i]    = 1'b0;
         rdy_inc[i]   = ch_start[i] & ch_ready[i];
         if (st_q[i] != IDLE) idle_now = 1'b0;
         case (st_q[i])
            IDLE: begin
               // A done without start is ignored here.
               if (ch_start[i]) begin
                  accept[i] = 1'b1;
                  if (!ch_done[i])         st_d[i] = BUSY;
                  else if (ch_continue[i]) txn_inc[i] = 1'b1;
                  else                     st_d[i] = WAIT_CONT;
               end
            end
            BUSY: begin
               busy_inc[i] = 1'b1;
               if (ch_done[i]) begin
                  if (ch_continue[i]) begin
                     txn_inc[i] = 1'b1;
                     accept[i]  = ch_start[i];
                     st_d[i]    = ch_start[i] ? BUSY : IDLE;
                  end else begin
                     st_d[i] = WAIT_CONT;
                  end
               end
            end
            WAIT_CONT: begin
               if (!ch_continue[i]) begin
                  stall_inc[i] = 1'b1;
               end else begin
                  txn_inc[i] = 1'b1;
                  accept[i]  = ch_start[i];
                  st_d[i]    = ch_start[i] ? BUSY : IDLE;
               end
            end
            default: st_d[i] = IDLE;
         endcase
         ovf_hit[i] = (txn_inc[i]   && sat_inc(txn_q[i])   == CNT_MAX) ||
                      (busy_inc[i]  && sat_inc(busy_q[i])  == CNT_MAX) ||
                      (stall_inc[i] && sat_inc(stall_q[i]) == CNT_MAX) ||
                      (rdy_inc[i]   && sat_inc(ready_q[i]) == CNT_MAX);
`ifdef HLS_PERF_MAXLAT_EN
         // lat_cur = latency of the current transaction including this cycle.
         // WAIT_CONT holds the value captured in the done cycle.
         case (st_q[i])
            IDLE:    lat_cur[i] = CNT_W'(1);
            BUSY:    lat_cur[i] = sat_inc(lat_q[i]);
            default: lat_cur[i] = lat_q[i];
         endcase
         lat_d[i] = accept[i] ? CNT_W'(1) : lat_cur[i];
         max_d[i] = (txn_inc[i] && (lat_cur[i] > max_q[i])) ? lat_cur[i] : max_q[i];
         if (max_d[i] == CNT_MAX) ovf_hit[i] = 1'b1;
`endif
      end
   end

   // Channel FSMs always track; counters only move when gated in.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i]    <= IDLE;
            txn_q[i]   <= '0;
            busy_q[i]  <= '0;
            stall_q[i] <= '0;
            ready_q[i] <= '0;
`ifdef HLS_PERF_MAXLAT_EN
            lat_q[i]   <= '0;
            max_q[i]   <= '0;
`endif
         end
         ovf_q <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i]    <= IDLE;
            txn_q[i]   <= '0;
            busy_q[i]  <= '0;
            stall_q[i] <= '0;
            ready_q[i] <= '0;
`ifdef HLS_PERF_MAXLAT_EN
            lat_q[i]   <= '0;
            max_q[i]   <= '0;
`endif
         end
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i] <= st_d[i];
`ifdef HLS_PERF_MAXLAT_EN
            lat_q[i] <= lat_d[i];
`endif
            if (count_en) begin
               if (txn_inc[i])   txn_q[i]   <= sat_inc(txn_q[i]);
               if (busy_inc[i])  busy_q[i]  <= sat_inc(busy_q[i]);
               if (stall_inc[i]) stall_q[i] <= sat_inc(stall_q[i]);
               if (rdy_inc[i])   ready_q[i] <= sat_inc(ready_q[i]);
               if (ovf_hit[i])   ovf_q[i]   <= 1'b1;
`ifdef HLS_PERF_MAXLAT_EN
               max_q[i] <= max_d[i];
`endif
            end
         end
      end
   end

   // Read mux works on the registered counters, so a read coinciding with an
   // increment returns the pre-increment value.
   logic [CNT_W-1:0] rd_val;
   logic             sel_ok;
   logic             rd_bad;

   always_comb begin
      rd_val = '0;
      sel_ok = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            sel_ok = 1'b1;
            case (rd_field)
               3'd0:    rd_val = txn_q[i];
               3'd1:    rd_val = busy_q[i];
               3'd2:    rd_val = stall_q[i];
               3'd3:    rd_val = ready_q[i];
`ifdef HLS_PERF_MAXLAT_EN
               3'd4:    rd_val = max_q[i];
`else
               3'd4:    rd_val = '0;
`endif
               3'd5:    rd_val = CNT_W'({st_q[i], ovf_q[i]});
               default: rd_val = '0;
            endcase
         end
      end
      rd_bad = !sel_ok || (rd_field > 3'd5);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         rd_err      <= 1'b0;
         all_idle    <= 1'b1;
         finish_seen <= 1'b0;
      end else if (clear) begin
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         rd_err      <= 1'b0;
         all_idle    <= 1'b1;
         finish_seen <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         rd_err   <= rd_req & rd_bad;
         if (rd_req) rd_data <= rd_bad ? '0 : rd_val;
         all_idle <= idle_now;
         if (finish) finish_seen <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hls_handshake_perf_monitor.sv
// Purpose : self-checking bench for hls_handshake_perf_monitor (NUM_CH=4, CNT_W=8).
// Latency : read responses checked against a queue of expectations one cycle after each request.
// Backpressure: none; status outputs are checked inline by each scenario task.
module tb_hls_handshake_perf_monitor;

   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int SW  = 4;

   logic           clock = 1'b0;
   logic           reset;
   logic           enable, clear, finish;
   logic [NCH-1:0] ch_start, ch_ready, ch_done, ch_continue;
   logic [SW-1:0]  rd_sel;
   logic [2:0]     rd_field;
   logic           rd_req;
   logic [CW-1:0]  rd_data;
   logic           rd_valid, rd_err, all_idle, any_overflow, finish_seen;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [CW-1:0] data;
      logic          err;
      int            tag;
   } exp_t;
   exp_t exp_q[$];

   hls_handshake_perf_monitor #(.NUM_CH(NCH), .CNT_W(CW), .SEL_W(SW)) dut (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear), .finish(finish),
      .ch_start(ch_start), .ch_ready(ch_ready), .ch_done(ch_done), .ch_continue(ch_continue),
      .rd_sel(rd_sel), .rd_field(rd_field), .rd_req(rd_req),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
      .all_idle(all_idle), .any_overflow(any_overflow), .finish_seen(finish_seen)
   );

   always #5 clock = ~clock;

   // Scoreboard: every response is matched against the oldest pending expectation.
   always @(negedge clock) begin
      if (rd_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: rd_valid=1 data=%0d err=%0b with no request pending", rd_data, rd_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (rd_data !== e.data || rd_err !== e.err) begin
               n_fail++;
               $display("FAIL rd_tag%0d: got data=%0d err=%0b, expected data=%0d err=%0b",
                        e.tag, rd_data, rd_err, e.data, e.err);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      rd_req = 1'b0;
   endtask

   task automatic rd_push(input int sel, input int field, input logic [CW-1:0] d,
                          input logic e, input int tag);
      exp_t x;
      rd_sel   = SW'(sel);
      rd_field = 3'(field);
      rd_req   = 1'b1;
      x.data = d; x.err = e; x.tag = tag;
      exp_q.push_back(x);
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; clear = 1'b0; finish = 1'b0;
      ch_start = '0; ch_ready = '0; ch_done = '0; ch_continue = '1;
      rd_sel = '0; rd_field = '0; rd_req = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if ({rd_valid, rd_err, rd_data, any_overflow, finish_seen} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%0b err=%0b data=%0d ovf=%0b fin=%0b, expected all 0",
                  rd_valid, rd_err, rd_data, any_overflow, finish_seen);
      end
      n_checks++;
      if (all_idle !== 1'b1) begin
         n_fail++; $display("FAIL reset_all_idle: got %0b expected 1", all_idle);
      end
      // Put ch0 into BUSY, confirm state, then reset mid-run.
      ch_start[0] = 1'b1; tick(); ch_start[0] = 1'b0;
      repeat (2) tick();
      rd_push(0, 5, 8'd2, 1'b0, 1); tick();
      repeat (2) tick();
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({rd_valid, rd_err, rd_data, any_overflow, finish_seen} !== '0 || all_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL midrun_reset: valid=%0b err=%0b data=%0d ovf=%0b fin=%0b idle=%0b, expected 0s and idle=1",
                  rd_valid, rd_err, rd_data, any_overflow, finish_seen, all_idle);
      end
      tick();
      reset = 1'b1;
      tick();
      rd_push(0, 0, 8'd0, 1'b0, 2); tick();
      rd_push(0, 1, 8'd0, 1'b0, 3); tick();
      rd_push(0, 5, 8'd0, 1'b0, 4); tick();
      tick();
   endtask

   task automatic test_single_txn();
      ch_start[0] = 1'b1; ch_ready[0] = 1'b1;
      tick();                                   // c1
      ch_start[0] = 1'b0; ch_ready[0] = 1'b0;
      tick();                                   // c2
      tick();                                   // c3
      ch_done[0] = 1'b1;
      tick();                                   // c4
      ch_done[0] = 1'b0;
      n_checks++;
      if (all_idle !== 1'b0) begin
         n_fail++; $display("FAIL single_idle_c4: got %0b expected 0", all_idle);
      end
      tick();                                   // c5
      n_checks++;
      if (all_idle !== 1'b1) begin
         n_fail++; $display("FAIL single_idle_c5: got %0b expected 1", all_idle);
      end
      rd_push(0, 0, 8'd1, 1'b0, 10); tick();
      rd_push(0, 1, 8'd3, 1'b0, 11); tick();
      rd_push(0, 2, 8'd0, 1'b0, 12); tick();
      rd_push(0, 3, 8'd1, 1'b0, 13); tick();
`ifdef HLS_PERF_MAXLAT_EN
      rd_push(0, 4, 8'd4, 1'b0, 14); tick();
`else
      rd_push(0, 4, 8'd0, 1'b0, 14); tick();
`endif
      rd_push(0, 5, 8'd0, 1'b0, 15); tick();
      tick();
   endtask

   task automatic test_enable();
      enable = 1'b0;
      ch_start[0] = 1'b1; ch_done[0] = 1'b1; ch_ready[0] = 1'b1;
      tick();
      ch_start[0] = 1'b0; ch_done[0] = 1'b0; ch_ready[0] = 1'b0;
      enable = 1'b1;
      tick();
      rd_push(0, 0, 8'd1, 1'b0, 20); tick();
      rd_push(0, 3, 8'd1, 1'b0, 21); tick();
      tick();
   endtask

   task automatic test_stall();
      ch_start[1] = 1'b1; tick();               // c1
      ch_start[1] = 1'b0; tick();               // c2
      ch_done[1] = 1'b1; ch_continue[1] = 1'b0;
      tick();                                   // c3
      ch_done[1] = 1'b0;
      tick();                                   // c4
      rd_push(1, 5, 8'd4, 1'b0, 30);
      tick();                                   // c5
      n_checks++;
      if (all_idle !== 1'b0) begin
         n_fail++; $display("FAIL stall_idle: got %0b expected 0", all_idle);
      end
      tick();                                   // c6
      tick();                                   // c7
      ch_continue[1] = 1'b1;
      tick();                                   // c8
      rd_push(1, 2, 8'd4, 1'b0, 31); tick();
      rd_push(1, 0, 8'd1, 1'b0, 32); tick();
      rd_push(1, 1, 8'd2, 1'b0, 33); tick();
      rd_push(1, 5, 8'd0, 1'b0, 34); tick();
`ifdef HLS_PERF_MAXLAT_EN
      rd_push(1, 4, 8'd3, 1'b0, 35); tick();
`endif
      tick();
   endtask

   task automatic test_back_to_back();
      for (int cyc = 0; cyc < 30; cyc++) begin
         ch_start[2] = (cyc < 29);
         ch_done[2]  = (cyc % 3 == 2);
         if (cyc >= 2) begin
            n_checks++;
            if (all_idle !== 1'b0) begin
               n_fail++; $display("FAIL b2b_idle_c%0d: got %0b expected 0", cyc, all_idle);
            end
         end
         tick();
      end
      ch_start[2] = 1'b0; ch_done[2] = 1'b0;
      tick();
      n_checks++;
      if (all_idle !== 1'b1) begin
         n_fail++; $display("FAIL b2b_idle_end: got %0b expected 1", all_idle);
      end
      rd_push(2, 0, 8'd10, 1'b0, 40); tick();
      rd_push(2, 1, 8'd29, 1'b0, 41); tick();
`ifdef HLS_PERF_MAXLAT_EN
      rd_push(2, 4, 8'd4, 1'b0, 42); tick();
`endif
      finish = 1'b1; tick(); finish = 1'b0;
      n_checks++;
      if (finish_seen !== 1'b1) begin
         n_fail++; $display("FAIL finish_seen_set: got %0b expected 1", finish_seen);
      end
      repeat (2) begin
         ch_start[2] = 1'b1; ch_done[2] = 1'b1; tick();
         ch_start[2] = 1'b0; ch_done[2] = 1'b0; tick();
      end
      rd_push(2, 0, 8'd10, 1'b0, 43); tick();
      rd_push(2, 1, 8'd29, 1'b0, 44); tick();
      n_checks++;
      if (finish_seen !== 1'b1) begin
         n_fail++; $display("FAIL finish_seen_hold: got %0b expected 1", finish_seen);
      end
      tick();
   endtask

   task automatic test_saturation();
      clear = 1'b1; tick(); clear = 1'b0;
      n_checks++;
      if (finish_seen !== 1'b0 || all_idle !== 1'b1) begin
         n_fail++; $display("FAIL clear_status: fin=%0b idle=%0b expected fin=0 idle=1", finish_seen, all_idle);
      end
      rd_push(2, 0, 8'd0, 1'b0, 50); tick();
      ch_start[3] = 1'b1; tick(); ch_start[3] = 1'b0;
      repeat (254) tick();
      n_checks++;
      if (any_overflow !== 1'b0) begin
         n_fail++; $display("FAIL ovf_early: got %0b expected 0 at busy=254", any_overflow);
      end
      tick();
      n_checks++;
      if (any_overflow !== 1'b1) begin
         n_fail++; $display("FAIL ovf_set: got %0b expected 1 at busy=255", any_overflow);
      end
      repeat (44) tick();
      rd_push(3, 1, 8'd255, 1'b0, 51); tick();
      rd_push(3, 5, 8'd3, 1'b0, 52); tick();
      ch_done[3] = 1'b1; tick(); ch_done[3] = 1'b0; tick();
      rd_push(3, 0, 8'd1, 1'b0, 53); tick();
      rd_push(3, 5, 8'd1, 1'b0, 54); tick();
`ifdef HLS_PERF_MAXLAT_EN
      rd_push(3, 4, 8'd255, 1'b0, 55); tick();
`endif
      tick();
      clear = 1'b1; tick(); clear = 1'b0;
      n_checks++;
      if (any_overflow !== 1'b0) begin
         n_fail++; $display("FAIL ovf_clear: got %0b expected 0", any_overflow);
      end
      rd_push(3, 1, 8'd0, 1'b0, 56); tick();
      rd_push(3, 0, 8'd0, 1'b0, 57); tick();
      tick();
   endtask

   task automatic test_bad_read();
      rd_push(NCH, 0, 8'd0, 1'b1, 60); tick();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== 8'd0) begin
         n_fail++;
         $display("FAIL bad_sel: valid=%0b err=%0b data=%0d expected 1/1/0", rd_valid, rd_err, rd_data);
      end
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin
         n_fail++; $display("FAIL rd_idle: valid=%0b err=%0b expected 0/0", rd_valid, rd_err);
      end
      rd_push(0, 6, 8'd0, 1'b1, 61); tick();
      rd_push(0, 7, 8'd0, 1'b1, 62); tick();
      rd_push(15, 5, 8'd0, 1'b1, 63); tick();
      rd_push(0, 4, 8'd0, 1'b0, 64); tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_single_txn();
      test_enable();
      test_stall();
      test_back_to_back();
      test_saturation();
      test_bad_read();
      repeat (3) tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL rd_missing: %0d responses outstanding, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
